// File: rtl/uart_pkg.sv
// Shared types for the UART receive buffer: FIFO entry layout and capture FSM states.
package uart_pkg;

    localparam int ERR_W = 3;

    typedef struct packed {
        logic       ovr;
        logic       frm;
        logic       par;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } rx_fsm_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with explicit occupancy count.
// The head entry is presented combinationally from storage; a push while full
// and a pop while empty are both ignored.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 11,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign full     = (count == DEPTH_C);
    assign rd_valid = (count != '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && rd_valid;
    assign rd_data  = mem[rptr];

    // Storage write; data is not reset because the count qualifies every entry.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver: acknowledges each ready byte
// with a one-cycle active-low read pulse, stores byte plus error flags in a
// FWFT FIFO and keeps a sticky OR of all pushed error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             mclkx16,
    input  logic             reset,
    input  logic             rxrdy,
    input  logic [7:0]       dataout,
    input  logic             parityerr,
    input  logic             framingerr,
    input  logic             overrun,
    output logic             read,
    input  logic             pop,
    output logic [7:0]       rd_data,
    output logic [ERR_W-1:0] rd_err,
    output logic             rd_valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic [ERR_W-1:0] err_sticky,
    input  logic             clr_err
);

    rx_fsm_t          state;
    rx_entry_t        wr_entry;
    rx_entry_t        head;
    logic             push;
    logic [ERR_W-1:0] push_flags;

    // Capture only from IDLE and only when the registered full flag allows it;
    // otherwise the byte is left waiting in the receiver.
    always_comb begin
        push          = (state == IDLE) && rxrdy && !full;
        wr_entry.ovr  = overrun;
        wr_entry.frm  = framingerr;
        wr_entry.par  = parityerr;
        wr_entry.data = dataout;
    end

    assign push_flags = {overrun, framingerr, parityerr};

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rx_entry_t)),
        .AW    (AW)
    ) u_fifo (
        .clk      (mclkx16),
        .rst      (reset),
        .push     (push),
        .wr_data  (wr_entry),
        .pop      (pop),
        .rd_data  (head),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full)
    );

    assign rd_data = head.data;
    assign rd_err  = {head.ovr, head.frm, head.par};

    // Acknowledge FSM: one-cycle low read pulse, then wait for rxrdy to drop so a
    // slow-falling rxrdy cannot cause a second capture of the same byte.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            read  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (push) begin
                        read  <= 1'b0;
                        state <= ACK;
                    end
                end
                ACK: begin
                    read  <= 1'b1;
                    state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!rxrdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    read  <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error summary; a clear coinciding with a push keeps only the new flags.
    always_ff @(posedge mclkx16 or posedge reset) begin
        if (reset) begin
            err_sticky <= '0;
        end else if (push) begin
            err_sticky <= (clr_err ? '0 : err_sticky) | push_flags;
        end else if (clr_err) begin
            err_sticky <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: single byte, held rxrdy, fill to full,
// error flags, continuous push+pop across wrap, and reset during the ack pulse.
module tb_uart_rx_fifo;

    logic       mclkx16;
    logic       reset;
    logic       rxrdy;
    logic [7:0] dataout;
    logic       parityerr;
    logic       framingerr;
    logic       overrun;
    logic       read;
    logic       pop;
    logic [7:0] rd_data;
    logic [2:0] rd_err;
    logic       rd_valid;
    logic [4:0] count;
    logic       full;
    logic [2:0] err_sticky;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];

    uart_rx_fifo #(.DEPTH(16)) dut (
        .mclkx16    (mclkx16),
        .reset      (reset),
        .rxrdy      (rxrdy),
        .dataout    (dataout),
        .parityerr  (parityerr),
        .framingerr (framingerr),
        .overrun    (overrun),
        .read       (read),
        .pop        (pop),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .rd_valid   (rd_valid),
        .count      (count),
        .full       (full),
        .err_sticky (err_sticky),
        .clr_err    (clr_err)
    );

    initial mclkx16 = 1'b0;
    always #5 mclkx16 = ~mclkx16;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclkx16);
        #1;
    endtask

    // One received byte: capture edge, ack edge, return to IDLE.
    task automatic send_byte(input logic [7:0] d, input logic [2:0] f);
        dataout = d;
        {overrun, framingerr, parityerr} = f;
        rxrdy = 1'b1;
        tick();
        check("ack_low", read, 0);
        rxrdy = 1'b0;
        tick();
        check("ack_high", read, 1);
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d, input logic [2:0] f);
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, d);
        check({tag, "_err"}, rd_err, f);
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxrdy = 1'b0; dataout = 8'h00; parityerr = 1'b0;
        framingerr = 1'b0; overrun = 1'b0; pop = 1'b0; clr_err = 1'b0;
        tick();
        tick();
        check("rst_read", read, 1);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_sticky", err_sticky, 0);
        reset = 1'b0;
        tick();

        // Single byte
        dataout = 8'hA5; rxrdy = 1'b1;
        tick();
        check("single_read_low", read, 0);
        check("single_valid", rd_valid, 1);
        check("single_data", rd_data, 8'hA5);
        check("single_err", rd_err, 3'b000);
        check("single_count", count, 1);
        rxrdy = 1'b0;
        tick();
        check("single_read_high", read, 1);
        tick();
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("single_pop_count", count, 0);
        check("single_pop_valid", rd_valid, 0);

        // rxrdy held high after the acknowledge
        dataout = 8'h33; rxrdy = 1'b1;
        tick();
        check("hold_ack", read, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_no_ack", read, 1);
        end
        check("hold_count", count, 1);
        rxrdy = 1'b0;
        tick();
        dataout = 8'h44; rxrdy = 1'b1;
        tick();
        check("hold_second_ack", read, 0);
        check("hold_count2", count, 2);
        rxrdy = 1'b0;
        tick();
        tick();
        pop_expect("hold_p0", 8'h33, 3'b000);
        pop_expect("hold_p1", 8'h44, 3'b000);

        // Fill to full, then a pending 17th byte
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 3'b000);
        end
        check("fill_full", full, 1);
        check("fill_count", count, 16);
        dataout = 8'hEE; rxrdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_no_ack", read, 1);
            check("full_count", count, 16);
        end
        check("full_head", rd_data, 8'h00);
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("full_pop_no_push", count, 15);
        check("full_pop_read", read, 1);
        check("full_pop_notfull", full, 0);
        tick();
        check("full_resume_ack", read, 0);
        check("full_resume_count", count, 16);
        rxrdy = 1'b0;
        tick();
        tick();
        for (int i = 1; i < 16; i++) begin
            pop_expect("full_drain", 8'(i), 3'b000);
        end
        pop_expect("full_last", 8'hEE, 3'b000);
        check("full_empty", rd_valid, 0);

        // Error flags and sticky summary
        send_byte(8'h11, 3'b001);
        send_byte(8'h22, 3'b010);
        check("sticky_or", err_sticky, 3'b011);
        pop_expect("err_p0", 8'h11, 3'b001);
        pop_expect("err_p1", 8'h22, 3'b010);
        check("sticky_after_pop", err_sticky, 3'b011);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("sticky_clr", err_sticky, 3'b000);
        send_byte(8'h5A, 3'b001);
        check("sticky_par", err_sticky, 3'b001);
        dataout = 8'h55; {overrun, framingerr, parityerr} = 3'b100;
        rxrdy = 1'b1; clr_err = 1'b1;
        tick();
        clr_err = 1'b0; rxrdy = 1'b0; overrun = 1'b0;
        check("sticky_clr_push", err_sticky, 3'b100);
        tick();
        tick();
        pop_expect("err_p2", 8'h5A, 3'b001);
        pop_expect("err_p3", 8'h55, 3'b100);

        // Continuous push and pop across pointer wrap
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hA0 + 8'(i), 3'b000);
            q.push_back(8'hA0 + 8'(i));
        end
        check("stream_start_count", count, 3);
        for (int i = 0; i < 40; i++) begin
            dataout = 8'(i * 7 + 3);
            rxrdy = 1'b1;
            pop = 1'b1;
            check("stream_head", rd_data, q[0]);
            void'(q.pop_front());
            q.push_back(8'(i * 7 + 3));
            tick();
            pop = 1'b0;
            rxrdy = 1'b0;
            check("stream_count", count, 3);
            check("stream_ack", read, 0);
            tick();
            tick();
        end
        while (q.size() > 0) begin
            pop_expect("stream_drain", q[0], 3'b000);
            void'(q.pop_front());
        end
        check("stream_empty", count, 0);

        // Reset asserted during the ACK cycle
        dataout = 8'h77; rxrdy = 1'b1;
        tick();
        check("rstmid_ack", read, 0);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid_read", read, 1);
        check("rstmid_count", count, 0);
        check("rstmid_valid", rd_valid, 0);
        rxrdy = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'h99, 3'b000);
        check("rstmid_new_count", count, 1);
        pop_expect("rstmid_p0", 8'h99, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
